// File: rtl/data_sram_responder_if.sv
// CPU data-SRAM bus: the core drives the request side and the responder returns
// read data plus a stall request.
interface data_sram_responder_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq_mem;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata,
        input  stallreq_mem
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata,
        output stallreq_mem
    );
endinterface

// File: rtl/data_sram_responder.sv
// Word-organised data SRAM responder with byte write enables, a registered read
// port and an optional wait-state counter that holds the pipeline via stallreq_mem.
module data_sram_responder #(
    parameter int ADDR_WORDS_LOG2 = 12,
    parameter int WAIT_CYCLES     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    data_sram_responder_if.slave  bus
);
    localparam int         DEPTH     = 1 << ADDR_WORDS_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]                 state_r;
    logic [3:0]                 cnt_r;
    logic [3:0]                 lat_wen_r;
    logic [ADDR_WORDS_LOG2-1:0] lat_idx_r;
    logic [31:0]                lat_wdata_r;
    logic [31:0]                rdata_r;
    logic [31:0]                mem_r [DEPTH];

    logic                       accept_s;
    logic [ADDR_WORDS_LOG2-1:0] req_idx_s;
    logic                       acc_go_s;
    logic [3:0]                 acc_wen_s;
    logic [ADDR_WORDS_LOG2-1:0] acc_idx_s;
    logic [31:0]                acc_wdata_s;
    logic                       stall_s;
    logic                       unused_addr_s;

    assign accept_s      = (state_r == ST_IDLE) && bus.data_sram_en;
    assign req_idx_s     = bus.data_sram_addr[ADDR_WORDS_LOG2+1:2];
    assign unused_addr_s = ^{bus.data_sram_addr[31:ADDR_WORDS_LOG2+2], bus.data_sram_addr[1:0]};

    // Select the access source: live bus with no wait states, latched request otherwise
    always_comb begin
        acc_go_s    = 1'b0;
        acc_wen_s   = 4'b0000;
        acc_idx_s   = '0;
        acc_wdata_s = 32'h0000_0000;
        stall_s     = 1'b0;
        if (WAIT_CYCLES == 0) begin
            acc_go_s    = accept_s;
            acc_wen_s   = bus.data_sram_wen;
            acc_idx_s   = req_idx_s;
            acc_wdata_s = bus.data_sram_wdata;
            stall_s     = 1'b0;
        end else begin
            acc_go_s    = (state_r == ST_WAIT) && (cnt_r == 4'd1);
            acc_wen_s   = lat_wen_r;
            acc_idx_s   = lat_idx_r;
            acc_wdata_s = lat_wdata_r;
            stall_s     = accept_s || ((state_r == ST_WAIT) && (cnt_r > 4'd1));
        end
    end

    // Wait-state FSM and countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (WAIT_CYCLES != 0)) begin
                        state_r <= ST_WAIT;
                        cnt_r   <= WAIT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd1) begin
                        state_r <= ST_IDLE;
                    end
                    cnt_r <= cnt_r - 4'd1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    // Capture the request on accept; bus changes during WAIT are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_wen_r   <= 4'b0000;
            lat_idx_r   <= '0;
            lat_wdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            lat_wen_r   <= bus.data_sram_wen;
            lat_idx_r   <= req_idx_s;
            lat_wdata_r <= bus.data_sram_wdata;
        end
    end

    // Registered read port; writes leave the previous read data in place
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (acc_go_s && (acc_wen_s == 4'b0000)) begin
            rdata_r <= mem_r[acc_idx_s];
        end
    end

    // Byte-lane writes; reset on the completing edge abandons the write
    always_ff @(posedge clk) begin
        if (!rst && acc_go_s) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wen_s[i]) begin
                    mem_r[acc_idx_s][8*i +: 8] <= acc_wdata_s[8*i +: 8];
                end
            end
        end
    end

    assign bus.data_sram_rdata = rdata_r;
    assign bus.stallreq_mem    = stall_s;
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: zero-wait table vectors plus hand sequences for
// two and three wait states, all read results checked through a scoreboard queue.
module tb_data_sram_responder;
    logic clk = 1'b0;
    logic rst0, rst2, rst3;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    data_sram_responder_if bus0 ();
    data_sram_responder_if bus2 ();
    data_sram_responder_if bus3 ();

    data_sram_responder #(.ADDR_WORDS_LOG2(4), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0), .bus(bus0));
    data_sram_responder #(.ADDR_WORDS_LOG2(12), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst2), .bus(bus2));
    data_sram_responder #(.ADDR_WORDS_LOG2(12), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3), .bus(bus3));

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          d;
        int          due;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs [14];
    sb_t  q [$];

    function automatic logic [31:0] rd(input int d);
        case (d)
            0:       return bus0.data_sram_rdata;
            2:       return bus2.data_sram_rdata;
            3:       return bus3.data_sram_rdata;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    function automatic logic [31:0] st(input int d);
        case (d)
            0:       return {31'd0, bus0.stallreq_mem};
            2:       return {31'd0, bus2.stallreq_mem};
            3:       return {31'd0, bus3.stallreq_mem};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_sb();
        while (q.size() > 0 && q[0].due <= cyc) begin
            if (q[0].due == cyc) begin
                chk($sformatf("sb_read_dut%0d_c%0d", q[0].d, q[0].due), rd(q[0].d), q[0].exp);
            end else begin
                tests++;
                fails++;
                $display("FAIL sb_missed_dut%0d: due %0d now %0d", q[0].d, q[0].due, cyc);
            end
            void'(q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_sb();
    endtask

    task automatic drive(input int d, input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
        case (d)
            0: begin
                bus0.data_sram_en = en; bus0.data_sram_wen = wen;
                bus0.data_sram_addr = addr; bus0.data_sram_wdata = wdata;
            end
            2: begin
                bus2.data_sram_en = en; bus2.data_sram_wen = wen;
                bus2.data_sram_addr = addr; bus2.data_sram_wdata = wdata;
            end
            3: begin
                bus3.data_sram_en = en; bus3.data_sram_wen = wen;
                bus3.data_sram_addr = addr; bus3.data_sram_wdata = wdata;
            end
            default: ;
        endcase
    endtask

    // One complete access on dut d (its wait count equals d); reads are scoreboarded
    task automatic access(input int d, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp, input string name);
        drive(d, 1'b1, wen, addr, wdata);
        if (wen == 4'b0000) q.push_back('{d, cyc + d + 1, exp});
        #1;
        chk({name, "_stall_accept"}, st(d), (d > 0) ? 32'd1 : 32'd0);
        for (int k = 1; k <= d; k++) begin
            tick();
            drive(d, 1'b0, 4'b0000, 32'h0, 32'h0);
            #1;
            chk($sformatf("%s_stall_w%0d", name, k), st(d), (k < d) ? 32'd1 : 32'd0);
        end
        tick();
        drive(d, 1'b0, 4'b0000, 32'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 4'h4, 32'h0000_0010, 32'h00AA_0000, 32'h0};
        vecs[3]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAA_BEEF};
        vecs[4]  = '{1'b1, 4'hF, 32'h0000_0004, 32'h1234_5678, 32'h0};
        vecs[5]  = '{1'b1, 4'h0, 32'h0000_0044, 32'h0,         32'h1234_5678};
        vecs[6]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'h1234_5678};
        vecs[7]  = '{1'b0, 4'hF, 32'h0000_0010, 32'hFFFF_FFFF, 32'h1234_5678};
        vecs[8]  = '{1'b0, 4'h0, 32'h0000_0044, 32'h0,         32'h1234_5678};
        vecs[9]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAA_BEEF};
        vecs[10] = '{1'b1, 4'h0, 32'h0000_0004, 32'h0,         32'h1234_5678};
        vecs[11] = '{1'b1, 4'h1, 32'h0000_0050, 32'h0000_00FF, 32'h0};
        vecs[12] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAA_BEFF};
        vecs[13] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'hDEAA_BEFF};

        rst0 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(2, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(3, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        tick();
        chk("reset_rdata0", rd(0), 32'h0);
        chk("reset_rdata2", rd(2), 32'h0);
        chk("reset_rdata3", rd(3), 32'h0);
        chk("reset_stall2", st(2), 32'h0);
        chk("reset_stall3", st(3), 32'h0);
        rst0 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        tick();

        // Zero wait states: table-driven
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].en) begin
                access(0, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].exp,
                       $sformatf("w0_v%0d", i));
            end else begin
                chk($sformatf("w0_v%0d_hold", i), rd(0), vecs[i].exp);
                drive(0, 1'b0, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
                #1;
                chk($sformatf("w0_v%0d_stall", i), st(0), 32'h0);
                tick();
            end
        end

        // Two wait states: preload, then a read whose bus changes mid-WAIT
        access(2, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, "w2_wr10");
        access(2, 4'hF, 32'h0000_0020, 32'h55AA_55AA, 32'h0, "w2_wr20");
        n = cyc;
        drive(2, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
        q.push_back('{2, n + 3, 32'hDEAD_BEEF});
        #1;
        chk("w2_stall_n", st(2), 32'd1);
        tick();
        drive(2, 1'b1, 4'hF, 32'h0000_0020, 32'h0BAD_0BAD);
        #1;
        chk("w2_stall_n1", st(2), 32'd1);
        tick();
        drive(2, 1'b1, 4'hF, 32'h0000_0020, 32'h0BAD_0BAD);
        #1;
        chk("w2_stall_n2", st(2), 32'd0);
        chk("w2_rdata_not_early", rd(2), 32'h0);
        tick();
        drive(2, 1'b1, 4'h0, 32'h0000_0020, 32'h0);
        q.push_back('{2, n + 6, 32'h55AA_55AA});
        #1;
        chk("w2_accept_n3", st(2), 32'd1);
        tick();
        drive(2, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        tick();
        tick();

        // Three wait states: reset abandons a pending write
        access(3, 4'hF, 32'h0000_0030, 32'h1111_2222, 32'h0, "w3_wr30");
        access(3, 4'h0, 32'h0000_0030, 32'h0, 32'h1111_2222, "w3_rd30");
        drive(3, 1'b1, 4'hF, 32'h0000_0030, 32'hFFFF_FFFF);
        #1;
        chk("w3_stall_m", st(3), 32'd1);
        tick();
        drive(3, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0;
        #1;
        chk("w3_rst_stall", st(3), 32'h0);
        chk("w3_rst_rdata", rd(3), 32'h0);
        tick();
        access(3, 4'h0, 32'h0000_0030, 32'h0, 32'h1111_2222, "w3_rd_after_rst");
        tick();

        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL sb_pending: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder end of the CPU data-SRAM interface; the MEM stage consumes its read data.
- Single-port, word-organised data memory with byte write enables and a one-cycle registered read path.
- A parameterised wait-state counter raises a stall request so slower memories can be modelled without changing the pipeline.
- Sits beside the core and is driven by the EX-stage data_sram_* outputs; data_sram_rdata returns to the MEM stage.

Parameters:
- ADDR_WORDS_LOG2, 12, log2 of the number of 32-bit words; capacity = 2^ADDR_WORDS_LOG2 words.
- WAIT_CYCLES, 0, number of stall cycles inserted per access; legal range 0..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- data_sram_en  input  1  access request for this cycle.
- data_sram_wen  input  4  byte write enables; bit i writes wdata[8i+7:8i]; 4'b0000 with en=1 means a read.
- data_sram_addr  input  32  byte address; bits [1:0] ignored.
- data_sram_wdata  input  32  write data, byte-lane aligned.
- data_sram_rdata  output  32  registered read data.
- stallreq_mem  output  1  stall request to the stall controller while an access is waiting.

Behaviour:
- Reset values: data_sram_rdata=0, stallreq_mem=0, FSM=IDLE, wait counter=0. Memory array is not cleared.
- Word index = addr[ADDR_WORDS_LOG2+1:2]. Higher address bits are ignored, so addresses alias modulo capacity.
- FSM states are IDLE and WAIT. Timing below is for an accepted request in cycle N.
- Accept: a request is accepted in cycle N when FSM=IDLE and en=1.
- Access edge: the access completes on the rising edge that ends cycle N+WAIT_CYCLES.
  - Write: each byte lane with wen[i]=1 is updated; other lanes are unchanged; data_sram_rdata holds its previous value.
  - Read: data_sram_rdata takes the word's value, visible in cycle N+WAIT_CYCLES+1.
- WAIT_CYCLES=0:
  - FSM never leaves IDLE; stallreq_mem stays 0.
  - Back-to-back accesses are accepted every cycle.
  - Read latency is exactly 1 cycle.
- WAIT_CYCLES=W>0:
  - Cycle N: en, wen, addr and wdata are latched; counter loads W; FSM moves to WAIT at the edge ending cycle N.
  - stallreq_mem is combinational: 1 when (IDLE and en) or (WAIT and counter>1). It is therefore high for exactly cycles N..N+W-1.
  - In WAIT the counter decrements each cycle. The access uses the latched values on the edge where counter=1, then the FSM returns to IDLE.
  - Inputs are ignored for the whole of WAIT; changes to en, addr or wdata in WAIT have no effect.
  - The next accept is possible at cycle N+W+1.
- Idle: when en=0 in IDLE there is no memory access, data_sram_rdata holds, and stallreq_mem=0.
- Read after write: a read of a word just written (including during stall) returns the merged new value.
- Reset mid-operation:
  - rst in any cycle of WAIT abandons the pending access; no write occurs.
  - FSM goes to IDLE, stallreq_mem to 0 and rdata to 0 on that edge.
  - rst takes priority over an access completing on the same edge.

Test Plan:
- WAIT_CYCLES=0 read after write:
  - Stimulus: write addr 0x10, wen=1111, wdata=0xDEADBEEF; next cycle read 0x10.
  - Response: rdata=0xDEADBEEF in the cycle after the read; stallreq_mem stays 0.
- Byte lanes:
  - Stimulus: with word 0x10=0xDEADBEEF, write wen=0100, wdata=0x00AA0000; then read 0x10.
  - Response: rdata=0xDEAABEEF.
- WAIT_CYCLES=2 read issued in cycle 5:
  - Response: stallreq_mem high in cycles 5–6 and low in 7.
  - rdata updates visible in cycle 8; the next request is accepted in cycle 8.
- WAIT_CYCLES=2, addr changed to 0x20 during WAIT:
  - Response: the read still returns the word at the originally latched address.
- WAIT_CYCLES=3 write, rst asserted in the second WAIT cycle:
  - Response: stallreq_mem=0 and rdata=0 the next cycle; a later read of that address shows the old contents.
- Aliasing, ADDR_WORDS_LOG2=4:
  - Stimulus: write 0x00000004=0x12345678; read 0x00000044.
  - Response: rdata=0x12345678. With en=0 for 3 cycles, rdata holds.
